// File: rtl/fetch_seq_ctrl.sv
// Fetch/hazard sequencer: drives PC and IF/ID enables, bubble injection, multi-word
// immediate fetch and prioritised edge-triggered interrupt entry with a PC push sequence.
module fetch_seq_ctrl #(
  parameter int          N_IRQ       = 4,
  parameter int          IMM_WORDS   = 1,
  parameter int          PUSH_CYCLES = 1,
  parameter logic [3:0]  IMM_OPCODE  = 4'd12,
  localparam int         VW          = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic [N_IRQ-1:0] irq,
  input  logic [3:0]       opcode,
  input  logic             rti_retire,
  output logic             PC_Write_En,
  output logic             IF_ID_Write_En,
  output logic             Inject_Bubble,
  output logic             Inject_Int,
  output logic [VW-1:0]    int_vec,
  output logic             int_push,
  output logic [1:0]       int_push_idx,
  output logic             in_service,
  output logic [N_IRQ-1:0] irq_pending
);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_FETCH     = 2'd1,
    S_FETCH_IMM = 2'd2,
    S_INT_ENTRY = 2'd3
  } state_t;

  localparam logic [2:0] IMM_LAST  = 3'(IMM_WORDS - 1);
  localparam logic [2:0] PUSH_LAST = 3'(PUSH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [N_IRQ-1:0]   pend_q, irq_d_q, rise, ack_mask;
  logic               insvc_q, bub_q, accept;
  logic [VW-1:0]      vec_q, take_idx;

  assign rise = irq & ~irq_d_q;

  // Lowest-index pending request has priority.
  always_comb begin
    take_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) take_idx = VW'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    PC_Write_En    = 1'b0;
    IF_ID_Write_En = 1'b0;
    Inject_Bubble  = 1'b1;
    accept         = 1'b0;
    case (state_q)
      S_RESET: begin
        PC_Write_En    = 1'b1;
        IF_ID_Write_En = 1'b1;
        state_d        = S_FETCH;
      end
      S_FETCH: begin
        PC_Write_En    = 1'b1;
        IF_ID_Write_En = 1'b1;
        Inject_Bubble  = 1'b0;
        if (stall_i) begin
          PC_Write_En    = 1'b0;
          IF_ID_Write_En = 1'b0;
        end else if ((|pend_q) && !insvc_q) begin
          accept        = 1'b1;
          Inject_Bubble = 1'b1;
          cnt_d         = '0;
          state_d       = S_INT_ENTRY;
        end else if (opcode == IMM_OPCODE) begin
          IF_ID_Write_En = 1'b0;
          Inject_Bubble  = 1'b1;
          cnt_d          = IMM_LAST;
          state_d        = S_FETCH_IMM;
        end
      end
      S_FETCH_IMM: begin
        if (stall_i) begin
          Inject_Bubble = bub_q;
        end else if (cnt_q == 3'd0) begin
          PC_Write_En    = 1'b1;
          IF_ID_Write_En = 1'b1;
          Inject_Bubble  = 1'b0;
          state_d        = S_FETCH;
        end else begin
          PC_Write_En = 1'b1;
          cnt_d       = cnt_q - 3'd1;
        end
      end
      S_INT_ENTRY: begin
        if (!stall_i) begin
          if (cnt_q == PUSH_LAST) state_d = S_FETCH;
          else                    cnt_d   = cnt_q + 3'd1;
        end
      end
      default: begin
        PC_Write_En    = 1'b1;
        IF_ID_Write_En = 1'b1;
        Inject_Bubble  = 1'b0;
        state_d        = S_FETCH;
      end
    endcase
    // Reset is asynchronous, so the enables must drop in the same cycle it rises.
    if (rst) begin
      PC_Write_En    = 1'b0;
      IF_ID_Write_En = 1'b0;
      Inject_Bubble  = 1'b1;
      accept         = 1'b0;
    end
  end

  always_comb begin
    ack_mask = '0;
    if (accept) ack_mask[take_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      pend_q  <= '0;
      irq_d_q <= '0;
      insvc_q <= 1'b0;
      vec_q   <= '0;
      bub_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_d_q <= irq;
      pend_q  <= (pend_q & ~ack_mask) | rise;
      bub_q   <= Inject_Bubble;
      if (accept) begin
        vec_q   <= take_idx;
        insvc_q <= 1'b1;
      end else if (rti_retire) begin
        insvc_q <= 1'b0;
      end
    end
  end

  assign Inject_Int   = accept;
  assign int_vec      = accept ? take_idx : vec_q;
  assign int_push     = (state_q == S_INT_ENTRY);
  assign int_push_idx = int_push ? cnt_q[1:0] : 2'd0;
  assign in_service   = insvc_q;
  assign irq_pending  = pend_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl (IMM_WORDS=3, PUSH_CYCLES=2): per-cycle vectors
// with hand-computed outputs feed an expected queue drained by a negedge monitor.
module tb_fetch_seq_ctrl;

  localparam int W = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall_i = 1'b0;
  logic [3:0] irq = 4'd0;
  logic [3:0] opcode = 4'd0;
  logic       rti_retire = 1'b0;

  logic       PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int;
  logic [1:0] int_vec;
  logic       int_push;
  logic [1:0] int_push_idx;
  logic       in_service;
  logic [3:0] irq_pending;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  fetch_seq_ctrl #(
    .N_IRQ(4), .IMM_WORDS(3), .PUSH_CYCLES(2), .IMM_OPCODE(4'd12)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .irq(irq), .opcode(opcode),
    .rti_retire(rti_retire), .PC_Write_En(PC_Write_En),
    .IF_ID_Write_En(IF_ID_Write_En), .Inject_Bubble(Inject_Bubble),
    .Inject_Int(Inject_Int), .int_vec(int_vec), .int_push(int_push),
    .int_push_idx(int_push_idx), .in_service(in_service),
    .irq_pending(irq_pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic pcw, input logic ifid, input logic bub,
                                      input logic ii, input logic [1:0] vec, input logic push,
                                      input logic [1:0] idx, input logic svc,
                                      input logic [3:0] pend);
    return {pcw, ifid, bub, ii, vec, push, idx, svc, pend};
  endfunction

  // driver: apply one cycle of inputs just after the rising edge, queue its expectation
  task automatic cyc(input string nm, input logic r, input logic st, input logic [3:0] iq,
                     input logic [3:0] op, input logic rti, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst = r; stall_i = st; irq = iq; opcode = op; rti_retire = rti;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got, e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int, int_vec, int_push,
             int_push_idx, in_service, irq_pending};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got pcw/ifid/bub/ii/vec/push/idx/svc/pend=%b required %b",
                 nm, got, e);
      end
    end
  end

  initial begin
    // reset held
    cyc("rst_hold0",   1, 0, 4'h0, 4'd0,  0, mk(0,0,1,0,2'd0,0,2'd0,0,4'h0));
    cyc("rst_hold1",   1, 0, 4'h0, 4'd0,  0, mk(0,0,1,0,2'd0,0,2'd0,0,4'h0));
    // release: RESET state, then steady FETCH
    cyc("reset_state", 0, 0, 4'h0, 4'd0,  0, mk(1,1,1,0,2'd0,0,2'd0,0,4'h0));
    cyc("fetch0",      0, 0, 4'h0, 4'd0,  0, mk(1,1,0,0,2'd0,0,2'd0,0,4'h0));
    cyc("fetch1",      0, 0, 4'h0, 4'd0,  0, mk(1,1,0,0,2'd0,0,2'd0,0,4'h0));
    // three-word immediate
    cyc("imm_fetch",   0, 0, 4'h0, 4'd12, 0, mk(1,0,1,0,2'd0,0,2'd0,0,4'h0));
    cyc("imm_w2",      0, 0, 4'h0, 4'd0,  0, mk(1,0,1,0,2'd0,0,2'd0,0,4'h0));
    cyc("imm_w1",      0, 0, 4'h0, 4'd0,  0, mk(1,0,1,0,2'd0,0,2'd0,0,4'h0));
    cyc("imm_w0",      0, 0, 4'h0, 4'd0,  0, mk(1,1,0,0,2'd0,0,2'd0,0,4'h0));
    // irq[2:1] rise together; bit 1 wins
    cyc("irq_edge",    0, 0, 4'h6, 4'd0,  0, mk(1,1,0,0,2'd0,0,2'd0,0,4'h0));
    cyc("accept1",     0, 0, 4'h6, 4'd0,  0, mk(1,1,1,1,2'd1,0,2'd0,0,4'h6));
    cyc("push1_0",     0, 0, 4'h6, 4'd0,  0, mk(0,0,1,0,2'd1,1,2'd0,1,4'h4));
    cyc("push1_1",     0, 0, 4'h6, 4'd0,  0, mk(0,0,1,0,2'd1,1,2'd1,1,4'h4));
    cyc("blocked",     0, 0, 4'h0, 4'd0,  0, mk(1,1,0,0,2'd1,0,2'd0,1,4'h4));
    // rti with pending: acceptance waits one cycle
    cyc("rti_pend",    0, 0, 4'h0, 4'd0,  1, mk(1,1,0,0,2'd1,0,2'd0,1,4'h4));
    cyc("accept2",     0, 0, 4'h0, 4'd0,  0, mk(1,1,1,1,2'd2,0,2'd0,0,4'h4));
    cyc("push2_stall", 0, 1, 4'h0, 4'd0,  0, mk(0,0,1,0,2'd2,1,2'd0,1,4'h0));
    cyc("push2_0",     0, 0, 4'h0, 4'd0,  0, mk(0,0,1,0,2'd2,1,2'd0,1,4'h0));
    cyc("push2_1",     0, 0, 4'h0, 4'd0,  0, mk(0,0,1,0,2'd2,1,2'd1,1,4'h0));
    cyc("rti_clear",   0, 0, 4'h0, 4'd0,  1, mk(1,1,0,0,2'd2,0,2'd0,1,4'h0));
    cyc("rti_idle",    0, 0, 4'h0, 4'd0,  1, mk(1,1,0,0,2'd2,0,2'd0,0,4'h0));
    cyc("fetch_stall", 0, 1, 4'h0, 4'd12, 0, mk(0,0,0,0,2'd2,0,2'd0,0,4'h0));
    // irq[0] during immediate fetch with a stall in the middle
    cyc("imm2_fetch",  0, 0, 4'h0, 4'd12, 0, mk(1,0,1,0,2'd2,0,2'd0,0,4'h0));
    cyc("imm2_w2_irq", 0, 0, 4'h1, 4'd0,  0, mk(1,0,1,0,2'd2,0,2'd0,0,4'h0));
    cyc("imm2_stall",  0, 1, 4'h1, 4'd0,  0, mk(0,0,1,0,2'd2,0,2'd0,0,4'h1));
    cyc("imm2_w1",     0, 0, 4'h1, 4'd0,  0, mk(1,0,1,0,2'd2,0,2'd0,0,4'h1));
    cyc("imm2_w0",     0, 0, 4'h1, 4'd0,  0, mk(1,1,0,0,2'd2,0,2'd0,0,4'h1));
    // acceptance beats a same-cycle rti
    cyc("accept0_rti", 0, 0, 4'h1, 4'd0,  1, mk(1,1,1,1,2'd0,0,2'd0,0,4'h1));
    cyc("push0_0",     0, 0, 4'h1, 4'd0,  0, mk(0,0,1,0,2'd0,1,2'd0,1,4'h0));
    cyc("push0_1_stl", 0, 1, 4'h1, 4'd0,  0, mk(0,0,1,0,2'd0,1,2'd1,1,4'h0));
    // reset lands inside the push sequence
    cyc("rst_mid",     1, 1, 4'h1, 4'd0,  0, mk(0,0,1,0,2'd0,0,2'd0,0,4'h0));
    cyc("rst_mid1",    1, 0, 4'h0, 4'd0,  0, mk(0,0,1,0,2'd0,0,2'd0,0,4'h0));
    cyc("reset_again", 0, 0, 4'h0, 4'd0,  0, mk(1,1,1,0,2'd0,0,2'd0,0,4'h0));
    cyc("fetch_again", 0, 0, 4'h0, 4'd0,  0, mk(1,1,0,0,2'd0,0,2'd0,0,4'h0));

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
